btn_conditioner: RTL

Upstream conditioner for the four directional push-buttons of the game board; its outputs drive the movement FSM directly.
- Synchronises the raw asynchronous, active-low buttons to clk and debounces each one.
- Presents clean active-low levels to the FSM, plus one-cycle press pulses for the score, random-number and move-step logic.
- Sits between the board pins and the movement FSM.

---
 rtl/btn_pkg.sv | 17 +
 rtl/debounce_channel.sv | 106 ++++++++++
 rtl/btn_conditioner.sv | 62 ++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Channel state encoding and press_pulse bit positions.
package btn_pkg;

    typedef enum logic [1:0] {
        S_UP,
        S_CHK_DN,
        S_DN,
        S_CHK_UP
    } db_state_t;

    localparam int IDX_IZQ = 0;
    localparam int IDX_DER = 1;
    localparam int IDX_ARR = 2;
    localparam int IDX_ABA = 3;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, 4-state debounce FSM with hold counter,
// registered active-low level and a one-cycle press strobe.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_btn,
    output logic o_btn_next,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
            $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn;
    logic             r_press;

    // Any reversion of the synchronised level inside a CHK state drops the
    // count, so only an unbroken run of DEBOUNCE_CYCLES+1 samples is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_UP;
            r_cnt   <= '0;
            r_btn   <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            case (r_state)
                S_UP: begin
                    if (!r_sync2) begin
                        r_state <= S_CHK_DN;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_CHK_DN: begin
                    if (r_sync2) begin
                        r_state <= S_UP;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_DN;
                        r_cnt   <= '0;
                        r_btn   <= 1'b0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DN: begin
                    if (r_sync2) begin
                        r_state <= S_CHK_UP;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_CHK_UP: begin
                    if (!r_sync2) begin
                        r_state <= S_DN;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_UP;
                        r_cnt   <= '0;
                        r_btn   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_UP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Level the output will take at the next edge, so the top can register
    // any_held in step with the debounced outputs.
    always_comb begin
        o_btn_next = r_btn;
        if (r_state == S_CHK_DN && !r_sync2 && r_cnt == CNT_MAX) begin
            o_btn_next = 1'b0;
        end else if (r_state == S_CHK_UP && r_sync2 && r_cnt == CNT_MAX) begin
            o_btn_next = 1'b1;
        end
    end

    assign o_btn   = r_btn;
    assign o_press = r_press;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the four directional buttons for the movement FSM: one
// debounce channel per button plus a registered any-button-held flag.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_izquierda_raw,
    input  logic       btn_derecha_raw,
    input  logic       btn_arriba_raw,
    input  logic       btn_abajo_raw,
    output logic       btn_izquierda,
    output logic       btn_derecha,
    output logic       btn_arriba,
    output logic       btn_abajo,
    output logic [3:0] press_pulse,
    output logic       any_held
);

    logic [3:0] w_raw;
    logic [3:0] w_btn;
    logic [3:0] w_btn_next;
    logic       r_any_held;

    assign w_raw[IDX_IZQ] = btn_izquierda_raw;
    assign w_raw[IDX_DER] = btn_derecha_raw;
    assign w_raw[IDX_ARR] = btn_arriba_raw;
    assign w_raw[IDX_ABA] = btn_abajo_raw;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_raw     (w_raw[g]),
                .o_btn     (w_btn[g]),
                .o_btn_next(w_btn_next[g]),
                .o_press   (press_pulse[g])
            );
        end
    endgenerate

    // Outputs are active-low, so "any pressed" means at least one bit is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_held <= 1'b0;
        end else begin
            r_any_held <= ~&w_btn_next;
        end
    end

    assign btn_izquierda = w_btn[IDX_IZQ];
    assign btn_derecha   = w_btn[IDX_DER];
    assign btn_arriba    = w_btn[IDX_ARR];
    assign btn_abajo     = w_btn[IDX_ABA];
    assign any_held      = r_any_held;

endmodule
